// File: rtl/window_hasher.sv
// MinHash sketch engine: one K-mer per cycle, per-function running minimum of h1, h2 bucket map at the end.
// Latency: start edge E0, K-mers on E1..E(NUM_KMERS), result and done pulse at E(NUM_KMERS+1); requests ignored while busy.
module window_hasher #(
  parameter  int SKETCH_SIZE    = 16,
  parameter  int NUM_OF_BUCKETS = 256,
  parameter  int WINDOW_SIZE    = 128,
  parameter  int KMER_SIZE      = 16,
  localparam int BW             = $clog2(NUM_OF_BUCKETS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready_for_hashing,
  input  logic [1:0]    window [0:WINDOW_SIZE-1],
  output logic [BW-1:0] hashedSketch [0:SKETCH_SIZE-1],
  output logic          hashing_is_done
);

  localparam int NUM_KMERS = WINDOW_SIZE - KMER_SIZE + 1;
  localparam int JW        = (NUM_KMERS > 1) ? $clog2(NUM_KMERS) : 1;
  localparam logic [JW-1:0] LAST_J = JW'(NUM_KMERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HASH, S_FINISH} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_win [0:WINDOW_SIZE-1];
  logic [31:0]   r_min [0:SKETCH_SIZE-1];
  logic [JW-1:0] r_j;
  logic [31:0]   w_kmer;
  logic [31:0]   w_h1 [0:SKETCH_SIZE-1];
  logic [BW-1:0] w_h2 [0:SKETCH_SIZE-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (ready_for_hashing) w_next = S_HASH;
      S_HASH:   if (r_j == LAST_J) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // The registered window shifts one base per K-mer, so the current K-mer is always its head.
  always_comb begin
    w_kmer = '0;
    for (int t = 0; t < KMER_SIZE; t++) begin
      w_kmer = {w_kmer[29:0], r_win[t]};
    end
  end

  always_comb begin
    for (int i = 0; i < SKETCH_SIZE; i++) begin
      w_h1[i] = 32'(2 * i + 1) * 32'h9E3779B1 * w_kmer + 32'(i) * 32'h7F4A7C15;
      w_h2[i] = BW'((r_min[i] * 32'h85EBCA6B) >> (32 - BW));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < WINDOW_SIZE; k++) r_win[k] <= '0;
      for (int i = 0; i < SKETCH_SIZE; i++) begin
        r_min[i]        <= '1;
        hashedSketch[i] <= '0;
      end
      r_j             <= '0;
      hashing_is_done <= 1'b0;
    end else begin
      hashing_is_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ready_for_hashing) begin
            for (int k = 0; k < WINDOW_SIZE; k++) r_win[k] <= window[k];
            for (int i = 0; i < SKETCH_SIZE; i++) r_min[i] <= '1;
            r_j <= '0;
          end
        end
        S_HASH: begin
          // Strict compare keeps the earlier value on ties.
          for (int i = 0; i < SKETCH_SIZE; i++) begin
            if (w_h1[i] < r_min[i]) r_min[i] <= w_h1[i];
          end
          for (int k = 0; k < WINDOW_SIZE - 1; k++) r_win[k] <= r_win[k+1];
          r_j <= r_j + 1'b1;
        end
        S_FINISH: begin
          for (int i = 0; i < SKETCH_SIZE; i++) hashedSketch[i] <= w_h2[i];
          hashing_is_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_window_hasher.sv
// Directed sequence with random windows for window_hasher; a plain-arithmetic MinHash model supplies expected sketches.
module tb_window_hasher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy, rdy_s;
  logic [1:0] win   [0:127];
  logic [1:0] win_s [0:3];
  logic [7:0] sk    [0:15];
  logic [0:0] sk_s  [0:15];
  logic       done, done_s;

  int n_checks = 0;
  int n_err    = 0;

  int unsigned mw      [0:127];
  logic [31:0] exp_a   [0:15];
  logic [31:0] exp_cur [0:15];

  always #5 clk = ~clk;

  window_hasher dut (
    .clk(clk), .reset(rst_n), .ready_for_hashing(rdy), .window(win),
    .hashedSketch(sk), .hashing_is_done(done)
  );

  window_hasher #(.SKETCH_SIZE(16), .NUM_OF_BUCKETS(2), .WINDOW_SIZE(4), .KMER_SIZE(4)) dut_s (
    .clk(clk), .reset(rst_n), .ready_for_hashing(rdy_s), .window(win_s),
    .hashedSketch(sk_s), .hashing_is_done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Minimum of h1 over all K-mers of mw[0..ws-1], then bucket map.
  function automatic void model(input int ws, input int ks, input int bw);
    logic [31:0] a, b, k, h, mn;
    for (int i = 0; i < 16; i++) begin
      a  = 32'(2 * i + 1) * 32'h9E3779B1;
      b  = 32'(i) * 32'h7F4A7C15;
      mn = 32'hFFFFFFFF;
      for (int j = 0; j <= ws - ks; j++) begin
        k = 32'd0;
        for (int t = 0; t < ks; t++) k = (k << 2) | 32'(mw[j + t]);
        h = a * k + b;
        if (h < mn) mn = h;
      end
      exp_a[i] = (mn * 32'h85EBCA6B) >> (32 - bw);
    end
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < 128; k++) begin
      if (mode == 0)      win[k] = 2'd0;
      else if (mode == 1) win[k] = 2'(k % 4);
      else                win[k] = 2'($urandom_range(3, 0));
    end
  endtask

  task automatic model_main();
    for (int k = 0; k < 128; k++) mw[k] = 32'(win[k]);
    model(128, 16, 8);
  endtask

  task automatic take_model();
    for (int i = 0; i < 16; i++) exp_cur[i] = exp_a[i];
  endtask

  task automatic check_sketch(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s[%0d]", tag, i), 32'(sk[i]), exp_cur[i]);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!done && n < limit);
  endtask

  // One request pulse; window is scrambled right after the start edge.
  task automatic run_once(input string tag, input int mode);
    int n;
    @(negedge clk);
    fill(mode);
    model_main();
    take_model();
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    fill(2);
    wait_done(200, n);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'd114);
    check_sketch(tag);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, cnt;
    logic [7:0] acc;
    rst_n = 1'b0;
    rdy   = 1'b0;
    rdy_s = 1'b0;
    fill(0);
    for (int k = 0; k < 4; k++) win_s[k] = 2'd0;
    #12;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | sk[i];
    check("rst_sketch", 32'(acc), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_s", 32'(done_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_once("zero", 0);
    check("zero_sk0", 32'(sk[0]), 32'd0);
    run_once("mod4", 1);
    run_once("rnd0", 2);

    // Abort mid-run with reset.
    @(negedge clk);
    fill(2);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | sk[i];
    check("abort_sketch", 32'(acc), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_pulse", 32'(cnt), 32'd0);
    run_once("after_abort", 2);

    // Request held high across three back-to-back runs.
    @(negedge clk);
    fill(2);
    model_main();
    take_model();
    rdy = 1'b1;
    @(posedge clk);
    #1;
    fill(2);
    model_main();
    for (int r = 0; r < 3; r++) begin
      wait_done(200, n);
      check($sformatf("hold%0d_done", r), 32'(done), 32'd1);
      check($sformatf("hold%0d_lat", r), 32'(n), 32'd114);
      check_sketch($sformatf("hold%0d", r));
      take_model();
      if (r == 2) rdy = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_pulse", r), 32'(done), 32'd0);
      if (r < 2) begin
        fill(2);
        model_main();
      end
    end

    // Single-K-mer configuration.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) win_s[k] = (r == 0) ? 2'(k % 4) : 2'($urandom_range(3, 0));
      for (int k = 0; k < 4; k++) mw[k] = 32'(win_s[k]);
      model(4, 4, 1);
      rdy_s = 1'b1;
      @(posedge clk);
      #1;
      rdy_s = 1'b0;
      n = 0;
      do begin
        @(posedge clk);
        n++;
        #1;
      end while (!done_s && n < 20);
      check($sformatf("small%0d_lat", r), 32'(n), 32'd2);
      for (int i = 0; i < 16; i++)
        check($sformatf("small%0d[%0d]", r, i), 32'(sk_s[i]), exp_a[i]);
      @(posedge clk);
      #1;
      check($sformatf("small%0d_pulse", r), 32'(done_s), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
